// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : binary32 field widths and constants, plus the fdiv state type.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int unsigned c_FRAC_W  = 23;
    localparam int unsigned c_EXP_W   = 8;
    localparam int unsigned c_BIAS    = 127;
    localparam int unsigned c_EXP_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } fdiv_state_t;

endpackage
`default_nettype wire

// File: rtl/fdiv_norm.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_norm
// Description : exponent adjust, truncation packing and zero/overflow handling
//               for the fdiv quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv_norm
    import fpu_pkg::*;
(
    input  logic                 s,
    input  logic [c_EXP_W-1:0]   e1,
    input  logic [c_EXP_W-1:0]   e2,
    input  logic [24:0]          q,
    output logic [31:0]          y,
    output logic                 ovf
);

    logic signed [9:0]       w_ee;
    logic signed [9:0]       w_exp;
    logic [c_FRAC_W-1:0]     w_frac;

    always_comb begin
        w_ee   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(10'(c_BIAS));
        w_exp  = q[24] ? w_ee : (w_ee - 10'sd1);
        w_frac = q[24] ? q[23:1] : q[22:0];
        y      = {s, 31'd0};
        ovf    = 1'b0;
        // Zero dividend beats zero divisor; exponent-0 inputs are flushed zeros.
        if (e1 == '0) begin
            y   = {s, 31'd0};
            ovf = 1'b0;
        end else if (e2 == '0) begin
            y   = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (w_exp <= 10'sd0) begin
            y   = {s, 31'd0};
            ovf = 1'b0;
        end else if (w_exp >= $signed(10'(c_EXP_MAX))) begin
            y   = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            y   = {s, w_exp[7:0], w_frac};
            ovf = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdiv.sv
`default_nettype none
// ============================================================================
// Module      : fdiv
// Description : binary32 divider, restoring mantissa division at one quotient
//               bit per cycle, fixed 26-edge latency, valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    fdiv_state_t        r_state;
    fdiv_state_t        w_next;
    logic [4:0]         r_cnt;
    logic               r_s;
    logic [c_EXP_W-1:0] r_e1;
    logic [c_EXP_W-1:0] r_e2;
    logic [23:0]        r_mb;
    logic [25:0]        r_rem;
    logic [24:0]        r_q;
    logic [31:0]        r_y;
    logic               r_ovf;

    logic               w_ge;
    logic [25:0]        w_sub;
    logic [31:0]        w_norm_y;
    logic               w_norm_ovf;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_CALC;
            end
            ST_CALC: begin
                if (r_cnt == 5'd0) w_next = ST_NORM;
            end
            ST_NORM: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // One restoring step: trial subtract, keep the difference if it fits, shift.
    always_comb begin
        w_ge  = (r_rem >= {2'b00, r_mb});
        w_sub = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= 5'd0;
            r_s   <= 1'b0;
            r_e1  <= '0;
            r_e2  <= '0;
            r_mb  <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_y   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= 5'd24;
                        r_s   <= x1[31] ^ x2[31];
                        r_e1  <= x1[30:23];
                        r_e2  <= x2[30:23];
                        r_mb  <= {1'b1, x2[22:0]};
                        r_rem <= {3'b001, x1[22:0]};
                        r_q   <= '0;
                    end
                end
                ST_CALC: begin
                    r_q   <= {r_q[23:0], w_ge};
                    r_rem <= w_sub << 1;
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                ST_NORM: begin
                    r_y   <= w_norm_y;
                    r_ovf <= w_norm_ovf;
                end
                default: ;
            endcase
        end
    end

    fdiv_norm u_norm (
        .s   (r_s),
        .e1  (r_e1),
        .e2  (r_e2),
        .q   (r_q),
        .y   (w_norm_y),
        .ovf (w_norm_ovf)
    );

    assign y   = r_y;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdiv
// Description : self-checking bench for fdiv with an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdiv;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] y;
    logic        ovf;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb_q[$];

    fdiv dut (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: quotient by integer division of scaled mantissas, returns {y, ovf}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [49:0] num, den, q;
        int          e;
        logic [22:0] frac;
        s   = a[31] ^ b[31];
        num = {2'b00, 1'b1, a[22:0], 24'd0};
        den = {26'd0, 1'b1, b[22:0]};
        q   = num / den;
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[24]) frac = q[23:1];
        else begin
            e    = e - 1;
            frac = q[22:0];
        end
        if (a[30:23] == 8'd0)      return {s, 31'd0, 1'b0};
        else if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0, 1'b1};
        else if (e <= 0)           return {s, 31'd0, 1'b0};
        else if (e >= 255)         return {s, 8'hFF, 23'd0, 1'b1};
        else                       return {s, e[7:0], frac, 1'b0};
    endfunction

    // Drives one operation, waits for its result and consumes it when out_ready is high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] gy, output logic gov,
                          output int lat, output bit tmo);
        sb_q.push_back(model(a, b));
        @(negedge clk);
        x1 = a; x2 = b; in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; tmo = 1'b1; gy = '0; gov = 1'b0;
        for (int i = 0; i < 100 && tmo; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) begin
                tmo = 1'b0;
                gy  = y;
                gov = ovf;
            end
        end
        if (!tmo && out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        total++; if (y !== 32'd0)      begin bad++; $display("FAIL reset_y: got %h want 00000000", y); end
        total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] gy; logic gov; int lat; bit tmo; logic [32:0] e;
        run_op(32'h40C00000, 32'h40000000, gy, gov, lat, tmo);
        e = sb_q.pop_front();
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout: no out_valid"); end
        total++; if (lat !== 26) begin bad++; $display("FAIL basic_latency: got %0d want 26", lat); end
        total++; if (gy !== 32'h40400000) begin bad++; $display("FAIL basic_y: got %h want 40400000", gy); end
        total++; if (gov !== e[0]) begin bad++; $display("FAIL basic_ovf: got %b want %b", gov, e[0]); end
    endtask

    task automatic test_truncation();
        logic [31:0] gy; logic gov; int lat; bit tmo; logic [32:0] e;
        run_op(32'h3F800000, 32'h40400000, gy, gov, lat, tmo);
        e = sb_q.pop_front();
        total++; if (tmo || gy !== 32'h3EAAAAAA) begin bad++; $display("FAIL trunc_y: got %h want 3eaaaaaa", gy); end
        total++; if (gy !== e[32:1]) begin bad++; $display("FAIL trunc_model: got %h want %h", gy, e[32:1]); end
    endtask

    task automatic test_zero_cases();
        logic [31:0] gy; logic gov; int lat; bit tmo; logic [32:0] e;
        logic [31:0] ta[3] = '{32'h3F800000, 32'h80000000, 32'h00000000};
        logic [31:0] tb[3] = '{32'h00000000, 32'h40000000, 32'h00000000};
        logic [32:0] te[3] = '{{32'h7F800000, 1'b1}, {32'h80000000, 1'b0}, {32'h00000000, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], gy, gov, lat, tmo);
            e = sb_q.pop_front();
            total++;
            if (tmo || {gy, gov} !== te[i] || {gy, gov} !== e)
                begin bad++; $display("FAIL zero_case%0d: got %h/%b want %h/%b", i, gy, gov, te[i][32:1], te[i][0]); end
            total++; if (lat !== 26) begin bad++; $display("FAIL zero_latency%0d: got %0d want 26", i, lat); end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] gy; logic gov; int lat; bit tmo; logic [32:0] e;
        run_op(32'h7F000000, 32'h3F000000, gy, gov, lat, tmo);
        e = sb_q.pop_front();
        total++; if (tmo || gy !== 32'h7F800000 || gov !== 1'b1 || {gy, gov} !== e)
            begin bad++; $display("FAIL bound_ovf: got %h/%b want 7f800000/1", gy, gov); end
        run_op(32'h00800000, 32'h40000000, gy, gov, lat, tmo);
        e = sb_q.pop_front();
        total++; if (tmo || gy !== 32'h00000000 || gov !== 1'b0 || {gy, gov} !== e)
            begin bad++; $display("FAIL bound_uflow: got %h/%b want 00000000/0", gy, gov); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] gy, a, b; logic gov; int lat; bit tmo; logic [32:0] e;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if (i < 8) begin
                a[30:23] = 8'($urandom_range(64, 190));
                b[30:23] = 8'($urandom_range(64, 190));
            end
            run_op(a, b, gy, gov, lat, tmo);
            e = sb_q.pop_front();
            total++;
            if (tmo || lat !== 26 || {gy, gov} !== e)
                begin bad++; $display("FAIL rand%0d %h/%h: got %h/%b lat %0d want %h/%b", i, a, b, gy, gov, lat, e[32:1], e[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e; logic [31:0] y0; bit seen;
        out_ready = 1'b0;
        sb_q.push_back(model(32'h40C00000, 32'h40000000));
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 x1 = 32'h3F800000; x2 = 32'h40400000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_calc_ready%0d: got %b want 0", i, in_ready); end
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        in_valid = 1'b0;
        e = sb_q.pop_front();
        total++; if (!seen || y !== e[32:1] || ovf !== e[0])
            begin bad++; $display("FAIL bp_result: got %h/%b want %h/%b", y, ovf, e[32:1], e[0]); end
        y0 = y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== y0)
                begin bad++; $display("FAIL bp_hold%0d: got v%b r%b %h want v1 r0 %h", i, out_valid, in_ready, y, y0); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_release: got v%b r%b want v0 r1", out_valid, in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL bp_second_op: got out_valid 1 want 0"); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] gy; logic gov; int lat; bit tmo; logic [32:0] e; bit seen;
        sb_q.push_back(model(32'h40C00000, 32'h40000000));
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        void'(sb_q.pop_front());
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL rst_mid_now: got v%b r%b want v0 r1", out_valid, in_ready); end
        total++; if (y !== 32'd0 || ovf !== 1'b0)
            begin bad++; $display("FAIL rst_mid_y: got %h/%b want 00000000/0", y, ovf); end
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL rst_mid_ghost: got out_valid 1 want 0"); end
        run_op(32'h3F800000, 32'h40400000, gy, gov, lat, tmo);
        e = sb_q.pop_front();
        total++; if (tmo || gy !== 32'h3EAAAAAA || {gy, gov} !== e)
            begin bad++; $display("FAIL rst_mid_after: got %h/%b want 3eaaaaaa/0", gy, gov); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        test_basic();
        test_truncation();
        test_zero_cases();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
